// File: rtl/gprs_wb_arbiter_if.sv
// Write-back bus between the execute/memory stages and gprs_wb_arbiter.
// It carries the ALU and LSU result handshakes and the registered gprs write port.
interface gprs_wb_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5
);
  logic              alu_valid;
  logic              alu_ready;
  logic [REG_AW-1:0] alu_rd;
  logic [DATA_W-1:0] alu_data;
  logic              lsu_valid;
  logic              lsu_ready;
  logic [REG_AW-1:0] lsu_rd;
  logic [DATA_W-1:0] lsu_data;
  logic              wena;
  logic [REG_AW-1:0] waddr;
  logic [DATA_W-1:0] wdata;
  logic              lsu_empty;

  modport master (
    output alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    input  alu_ready, lsu_ready, wena, waddr, wdata, lsu_empty
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data, lsu_valid, lsu_rd, lsu_data,
    output alu_ready, lsu_ready, wena, waddr, wdata, lsu_empty
  );
endinterface

// File: rtl/gprs_wb_arbiter.sv
// Merges ALU results and FIFO-buffered LSU load results into one registered gprs write port.
// Optional feature macro WB_BYPASS_EN forwards the in-flight write to the two read ports.
module gprs_wb_arbiter #(
  parameter int DATA_W     = 32,
  parameter int REG_AW     = 5,
  parameter int LSU_DEPTH  = 2,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  gprs_wb_arbiter_if.slave  bus
`ifdef WB_BYPASS_EN
  ,
  input  logic [REG_AW-1:0] raddr1,
  input  logic [REG_AW-1:0] raddr2,
  input  logic [DATA_W-1:0] gdata1,
  input  logic [DATA_W-1:0] gdata2,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] rdata2
`endif
);

  localparam int PW = $clog2(LSU_DEPTH);
  localparam int CW = PW + 1;
  localparam int SW = $clog2(STARVE_MAX + 1);

  logic [REG_AW-1:0] rd_mem   [LSU_DEPTH];
  logic [DATA_W-1:0] data_mem [LSU_DEPTH];
  logic [PW-1:0]     wr_ptr, rd_ptr;
  logic [CW-1:0]     count;
  logic [SW-1:0]     starve_cnt;
  logic              wena_q, wr_from_lsu;
  logic [REG_AW-1:0] waddr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              full, head_valid, force_lsu, alu_win, push, pop;
  logic [REG_AW-1:0] head_rd;
  logic [DATA_W-1:0] head_data;

  // Head eligibility uses the registered count, so a push into an empty FIFO
  // only becomes poppable on the following cycle.
  always_comb begin
    full       = (count == CW'(LSU_DEPTH));
    head_valid = (count != '0);
    head_rd    = rd_mem[rd_ptr];
    head_data  = data_mem[rd_ptr];
    force_lsu  = head_valid && (starve_cnt == SW'(STARVE_MAX));
    alu_win    = bus.alu_valid && !force_lsu;
    pop        = head_valid && !alu_win;
    push       = bus.lsu_valid && !full;
  end

  assign bus.alu_ready = alu_win || !bus.alu_valid;
  assign bus.lsu_ready = !full;
  assign bus.wena      = wena_q;
  assign bus.waddr     = waddr_q;
  assign bus.wdata     = wdata_q;
  assign bus.lsu_empty = !head_valid && !wr_from_lsu;

  always_ff @(posedge clk) begin
    if (push) begin
      rd_mem[wr_ptr]   <= bus.lsu_rd;
      data_mem[wr_ptr] <= bus.lsu_data;
    end
  end

  // Writes to x0 are still consumed from their source but never raise wena.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      starve_cnt  <= '0;
      wena_q      <= 1'b0;
      waddr_q     <= '0;
      wdata_q     <= '0;
      wr_from_lsu <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);

      if (!head_valid || pop)
        starve_cnt <= '0;
      else if (starve_cnt != SW'(STARVE_MAX))
        starve_cnt <= starve_cnt + 1'b1;

      if (alu_win) begin
        wena_q  <= (bus.alu_rd != '0);
        waddr_q <= bus.alu_rd;
        wdata_q <= bus.alu_data;
      end else if (pop) begin
        wena_q  <= (head_rd != '0);
        waddr_q <= head_rd;
        wdata_q <= head_data;
      end else begin
        wena_q  <= 1'b0;
      end
      wr_from_lsu <= pop && (head_rd != '0);
    end
  end

`ifdef WB_BYPASS_EN
  always_comb begin
    rdata1 = (wena_q && (waddr_q == raddr1) && (waddr_q != '0)) ? wdata_q : gdata1;
    rdata2 = (wena_q && (waddr_q == raddr2) && (waddr_q != '0)) ? wdata_q : gdata2;
  end
`endif

endmodule

// File: tb/tb_gprs_wb_arbiter.sv
// Directed self-checking bench for gprs_wb_arbiter: reset, ALU path, contention,
// FIFO full, starvation override, x0 suppression and (if WB_BYPASS_EN) forwarding.
module tb_gprs_wb_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  gprs_wb_arbiter_if #(.DATA_W(32), .REG_AW(5)) bus ();

`ifdef WB_BYPASS_EN
  logic [4:0]  raddr1, raddr2;
  logic [31:0] gdata1, gdata2, rdata1, rdata2;
`endif

  gprs_wb_arbiter #(
    .DATA_W(32), .REG_AW(5), .LSU_DEPTH(2), .STARVE_MAX(4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef WB_BYPASS_EN
    ,
    .raddr1(raddr1),
    .raddr2(raddr2),
    .gdata1(gdata1),
    .gdata2(gdata2),
    .rdata1(rdata1),
    .rdata2(rdata2)
`endif
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compare one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present one cycle's worth of source inputs and let combinational outputs settle
  task automatic applyStimulus(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                               input logic lv, input logic [4:0] lrd, input logic [31:0] ldat);
    bus.alu_valid = av;
    bus.alu_rd    = ard;
    bus.alu_data  = adat;
    bus.lsu_valid = lv;
    bus.lsu_rd    = lrd;
    bus.lsu_data  = ldat;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkWrite(input string tag, input logic en, input logic [4:0] a, input logic [31:0] d);
    checkOutput({tag, "_wena"}, 32'(bus.wena), 32'(en));
    if (en) begin
      checkOutput({tag, "_waddr"}, 32'(bus.waddr), 32'(a));
      checkOutput({tag, "_wdata"}, bus.wdata, d);
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
`ifdef WB_BYPASS_EN
    raddr1 = '0; raddr2 = '0; gdata1 = '0; gdata2 = '0;
`endif
    rst_n = 1'b0;
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();
    checkOutput("rst_wena", 32'(bus.wena), 0);
    checkOutput("rst_waddr", 32'(bus.waddr), 0);
    checkOutput("rst_wdata", bus.wdata, 0);
    checkOutput("rst_lsu_ready", 32'(bus.lsu_ready), 1);
    checkOutput("rst_lsu_empty", 32'(bus.lsu_empty), 1);
    checkOutput("rst_alu_ready", 32'(bus.alu_ready), 1);
    rst_n = 1'b1;
    step();

    // ALU only
    applyStimulus(1, 5, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("alu_ready", 32'(bus.alu_ready), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("alu_only", 1, 5, 32'hDEADBEEF);
    step();
    checkOutput("idle_wena", 32'(bus.wena), 0);

    // ALU and LSU together: ALU first, load the cycle after
    applyStimulus(1, 3, 32'h33, 1, 7, 32'h77);
    checkOutput("cont_alu_ready", 32'(bus.alu_ready), 1);
    checkOutput("cont_lsu_ready", 32'(bus.lsu_ready), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("cont_n1", 1, 3, 32'h33);
    checkOutput("cont_not_empty", 32'(bus.lsu_empty), 0);
    step();
    checkWrite("cont_n2", 1, 7, 32'h77);
    checkOutput("cont_inflight", 32'(bus.lsu_empty), 0);
    step();
    checkOutput("cont_drained_wena", 32'(bus.wena), 0);
    checkOutput("cont_drained", 32'(bus.lsu_empty), 1);

    // Three loads against a continuously valid ALU
    applyStimulus(1, 1, 32'hA1, 1, 10, 32'hB0);
    step();
    applyStimulus(1, 1, 32'hA1, 1, 11, 32'hB1);
    checkOutput("full_ready_c1", 32'(bus.lsu_ready), 1);
    step();
    applyStimulus(1, 1, 32'hA1, 1, 12, 32'hB2);
    for (int i = 0; i < 3; i++) begin
      checkOutput("full_ready_low", 32'(bus.lsu_ready), 0);
      checkOutput("full_alu_ready", 32'(bus.alu_ready), 1);
      step();
    end
    checkOutput("full_forced_alu_ready", 32'(bus.alu_ready), 0);
    checkOutput("full_pop_cycle_ready", 32'(bus.lsu_ready), 0);
    step();
    checkWrite("full_l1", 1, 10, 32'hB0);
    checkOutput("full_ready_again", 32'(bus.lsu_ready), 1);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("full_alu", 1, 1, 32'hA1);
    step();
    checkWrite("full_l2", 1, 11, 32'hB1);
    step();
    checkWrite("full_l3", 1, 12, 32'hB2);
    step();
    checkOutput("full_drained", 32'(bus.lsu_empty), 1);

    // One load starved by a constant ALU stream
    applyStimulus(1, 2, 32'hE0, 1, 20, 32'hC0);
    step();
    applyStimulus(1, 2, 32'hE0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      checkOutput("starve_alu_ready", 32'(bus.alu_ready), 1);
      step();
    end
    checkOutput("starve_forced", 32'(bus.alu_ready), 0);
    step();
    checkWrite("starve_load", 1, 20, 32'hC0);
    checkOutput("starve_release", 32'(bus.alu_ready), 1);
    applyStimulus(0, 0, 0, 0, 0, 0);
    step();

    // x0 destinations from both sources are never written
    applyStimulus(1, 0, 32'h99, 1, 0, 32'h98);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("x0_alu_wena", 32'(bus.wena), 0);
    step();
    checkOutput("x0_lsu_wena", 32'(bus.wena), 0);
    checkOutput("x0_lsu_empty", 32'(bus.lsu_empty), 1);

    applyStimulus(1, 9, 32'h55, 0, 0, 0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("byp_write", 1, 9, 32'h55);
`ifdef WB_BYPASS_EN
    raddr1 = 9; gdata1 = 32'h11;
    raddr2 = 4; gdata2 = 32'h22;
    #1;
    checkOutput("byp_rdata1", rdata1, 32'h55);
    checkOutput("byp_rdata2", rdata2, 32'h22);
`endif

    // Asynchronous reset with a write and a queued load in flight
    applyStimulus(1, 8, 32'h88, 1, 21, 32'hD0);
    step();
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkWrite("pre_rst", 1, 8, 32'h88);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_wena", 32'(bus.wena), 0);
    checkOutput("arst_lsu_ready", 32'(bus.lsu_ready), 1);
    checkOutput("arst_lsu_empty", 32'(bus.lsu_empty), 1);
    step();
    rst_n = 1'b1;
    step();
    checkOutput("post_rst_wena", 32'(bus.wena), 0);
    checkOutput("post_rst_empty", 32'(bus.lsu_empty), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
